dmem_stream: RTL and testbench
==============================

Name: dmem_stream

Overview:
- Parametrised successor to the PE-local data memory in the spiral array.
- Keeps the vertical/horizontal in/out routing and adds a config register file and independent write/read address generators (base, stride, length).
- Adds a start/busy/done handshake, a registered read path and write-first collision bypass.
- Sits between neighbouring PEs: streams a vector in from one direction and replays it out to either direction without external address sequencing.

Parameters:
- DATA_W, 32, datum width of all data ports and memory words.
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- CNT_W, 8, element-count width; max stream length = 2**CNT_W-1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  load all cfg_* fields (ignored while busy)
- cfg_sel_i  in  2  write source: 0x none, 10 v_s_i, 11 h_s_i
- cfg_sel_o  in  2  read route: 0x none, 10 v_s_o, 11 h_s_o
- cfg_base_w  in  ADDR_W  write start address
- cfg_base_r  in  ADDR_W  read start address
- cfg_stride  in  ADDR_W  address increment, shared by both generators
- cfg_len  in  CNT_W  elements per channel
- start  in  1  begin a stream (ignored while busy)
- in_valid  in  1  write datum present this cycle
- rd_req  in  1  request next read element
- v_s_i  in  DATA_W  vertical input
- h_s_i  in  DATA_W  horizontal input
- v_s_o  out  DATA_W  vertical output
- h_s_o  out  DATA_W  horizontal output
- out_valid  out  1  read datum valid on the routed output
- busy  out  1  stream in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - state IDLE; wr_cnt, rd_cnt, addresses = 0.
  - Config regs = 0 (both selects "none").
  - All outputs = 0.
  - Memory contents are not reset.
- Config: on cfg_we in IDLE, all fields are registered; they take effect at the next start.
- FSM IDLE -> RUN:
  - Transition on start.
  - waddr <= base_w, raddr <= base_r, counters <= 0, busy = 1 from the next cycle.
  - If cfg_len == 0, go IDLE -> DONE instead.
- Write channel (RUN):
  - When sel_i = 1x, in_valid = 1 and wr_cnt < len: mem[waddr] <= selected input, waddr += stride, wr_cnt += 1.
  - sel_i = 0x: the channel counts as complete immediately and never writes.
- Read channel (RUN):
  - When sel_o = 1x, rd_req = 1 and rd_cnt < len: read mem[raddr], raddr += stride, rd_cnt += 1.
  - Data is registered and appears on the routed port the next cycle with out_valid = 1 (1-cycle latency).
  - The non-routed port is 0.
  - sel_o = 0x: the channel is complete immediately and out_valid stays 0.
- Collision: if a write and a read hit the same address in the same cycle, the read returns the newly written datum (write-first bypass).
- Wrap-around: address arithmetic is modulo 2**ADDR_W; the stride carry is discarded.
- Requests beyond len: extra in_valid or rd_req are ignored, with no write and no out_valid.
- RUN -> DONE:
  - Transition in the cycle after both channels are complete and the last read datum has been presented.
  - DONE lasts one cycle: done = 1, busy = 1.
  - Then DONE -> IDLE with busy = 0.
- Outputs between reads: out_valid = 0 and the output data is held at 0 on idle/non-read cycles.
- Reset mid-stream: returns immediately to IDLE with outputs 0. Memory writes already performed remain; no write occurs in the reset cycle.

Test Plan:
1. Write then read vertical:
   - Stimulus: cfg sel_i = 10, sel_o = 00, base_w = 4, stride = 1, len = 4; start; feed v_s_i 0xA0..0xA3 with in_valid.
   - Response: done pulses.
   - Then reconfigure sel_i = 00, sel_o = 10, base_r = 4; start; hold rd_req high. Response: v_s_o = 0xA0, A1, A2, A3 on 4 consecutive cycles with out_valid, h_s_o = 0.
2. Horizontal route with stride and wrap:
   - Stimulus: ADDR_W = 8, base_w = 0xFE, stride = 3, len = 3, h_s_i = 1, 2, 3.
   - Response: words land at 0xFE, 0x01, 0x04.
   - Read back with sel_o = 11. Response: h_s_o = 1, 2, 3 and v_s_o = 0.
3. Collision bypass:
   - Stimulus: base_w = base_r = 10, sel_i = 10, sel_o = 10, len = 1, in_valid and rd_req in the same cycle with v_s_i = 0x55.
   - Response: v_s_o = 0x55 one cycle later.
4. Gapped handshake:
   - Stimulus: len = 3, in_valid pattern 1, 0, 1, 0, 1.
   - Response: exactly 3 writes; done only after the third; start asserted mid-run is ignored.
5. len = 0:
   - Stimulus: start.
   - Response: done next cycle; no out_valid, no memory change.
6. Reset mid-stream:
   - Stimulus: assert rst after 2 of 4 writes.
   - Response: busy = 0, outputs = 0 next cycle; the 2 words already written remain readable in a new stream.

Source files
------------

// File: rtl/dmem_stream.sv
// dmem_stream: PE-local data memory with streaming address generators.
//
// A vector streams in from the vertical or horizontal input and is replayed
// out to either direction. Write and read channels each have their own
// base address; stride and length are shared. A stream is launched with
// start and reports completion with a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we            load all cfg_* fields (IDLE only)
//   cfg_sel_i         write source: 0x none, 10 v_s_i, 11 h_s_i
//   cfg_sel_o         read route:   0x none, 10 v_s_o, 11 h_s_o
//   cfg_base_w/_r     write/read start address
//   cfg_stride        address increment for both channels
//   cfg_len           elements per channel
//   start             begin a stream (IDLE only)
//   in_valid          write datum present
//   rd_req            request next read element
//   v_s_i, h_s_i      vertical / horizontal data inputs
//   v_s_o, h_s_o      vertical / horizontal data outputs (0 when not reading)
//   out_valid         read datum valid on the routed output
//   busy              stream in progress (RUN or DONE)
//   done              one-cycle completion pulse
module dmem_stream #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel_i,
  input  logic [1:0]        cfg_sel_o,
  input  logic [ADDR_W-1:0] cfg_base_w,
  input  logic [ADDR_W-1:0] cfg_base_r,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              start,
  input  logic              in_valid,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] v_s_i,
  input  logic [DATA_W-1:0] h_s_i,
  output logic [DATA_W-1:0] v_s_o,
  output logic [DATA_W-1:0] h_s_o,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [1:0]        sel_i, sel_o;
  logic [ADDR_W-1:0] base_w, base_r, stride;
  logic [CNT_W-1:0]  len;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic [DATA_W-1:0] v_q, h_q;
  logic              ov_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              wr_fire, rd_fire, wr_cmp, rd_cmp;
  logic [DATA_W-1:0] wdata, rd_word;

  assign wdata   = sel_i[0] ? h_s_i : v_s_i;
  assign wr_fire = (state == RUN) && sel_i[1] && in_valid && (wr_cnt < len);
  assign rd_fire = (state == RUN) && sel_o[1] && rd_req   && (rd_cnt < len);
  // An unselected channel has nothing to do, so it is complete from the start.
  assign wr_cmp  = !sel_i[1] || (wr_cnt == len);
  assign rd_cmp  = !sel_o[1] || (rd_cnt == len);
  // Write-first: a same-cycle write to the read address is forwarded.
  assign rd_word = (wr_fire && (waddr == raddr)) ? wdata : mem[raddr];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (len == '0) ? DONE : RUN;
      // Counters are registered, so the last read datum is already on the
      // output in the cycle both channels report complete.
      RUN:  if (wr_cmp && rd_cmp) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_i  <= '0;
      sel_o  <= '0;
      base_w <= '0;
      base_r <= '0;
      stride <= '0;
      len    <= '0;
      waddr  <= '0;
      raddr  <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      v_q    <= '0;
      h_q    <= '0;
      ov_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cfg_we) begin
        sel_i  <= cfg_sel_i;
        sel_o  <= cfg_sel_o;
        base_w <= cfg_base_w;
        base_r <= cfg_base_r;
        stride <= cfg_stride;
        len    <= cfg_len;
      end
      if (state == IDLE && start) begin
        waddr  <= base_w;
        raddr  <= base_r;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
      // Address sums truncate to ADDR_W, giving modulo-depth wrap.
      if (wr_fire) begin
        waddr  <= waddr + stride;
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_fire) begin
        raddr  <= raddr + stride;
        rd_cnt <= rd_cnt + 1'b1;
      end
      ov_q <= rd_fire;
      v_q  <= (rd_fire && !sel_o[0]) ? rd_word : '0;
      h_q  <= (rd_fire &&  sel_o[0]) ? rd_word : '0;
    end
  end

  // Storage is not reset; the write is suppressed during a reset cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[waddr] <= wdata;
  end

  assign v_s_o     = v_q;
  assign h_s_o     = h_q;
  assign out_valid = ov_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_dmem_stream.sv
module tb_dmem_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel_i, cfg_sel_o;
  logic [7:0]  cfg_base_w, cfg_base_r, cfg_stride, cfg_len;
  logic        start, in_valid, rd_req;
  logic [31:0] v_s_i, h_s_i, v_s_o, h_s_o;
  logic        out_valid, busy, done;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_v [8];

  dmem_stream #(.DATA_W(32), .ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel_i(cfg_sel_i),
    .cfg_sel_o(cfg_sel_o), .cfg_base_w(cfg_base_w), .cfg_base_r(cfg_base_r),
    .cfg_stride(cfg_stride), .cfg_len(cfg_len), .start(start),
    .in_valid(in_valid), .rd_req(rd_req), .v_s_i(v_s_i), .h_s_i(h_s_i),
    .v_s_o(v_s_o), .h_s_o(h_s_o), .out_valid(out_valid), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [1:0] si, input logic [1:0] so, input logic [7:0] bw,
                        input logic [7:0] br, input logic [7:0] st, input logic [7:0] ln);
    cfg_sel_i = si; cfg_sel_o = so; cfg_base_w = bw; cfg_base_r = br;
    cfg_stride = st; cfg_len = ln; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Write exp_v[0..n-1] back-to-back through the source chosen by si.
  task automatic wr_stream(input string tag, input logic [1:0] si, input logic [7:0] bw,
                           input logic [7:0] st, input int n);
    do_cfg(si, 2'b00, bw, 8'h00, st, n[7:0]);
    do_start();
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (si[0]) h_s_i = exp_v[i]; else v_s_i = exp_v[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk({tag, "_done"}, done, 1);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Read n words with rd_req held and compare against exp_v on the routed port.
  task automatic rd_stream(input string tag, input logic [1:0] so, input logic [7:0] br,
                           input logic [7:0] st, input int n);
    do_cfg(2'b00, so, 8'h00, br, st, n[7:0]);
    do_start();
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s_ov%0d", tag, i), out_valid, 1);
      chk($sformatf("%s_d%0d", tag, i), so[0] ? h_s_o : v_s_o, exp_v[i]);
      chk($sformatf("%s_z%0d", tag, i), so[0] ? v_s_o : h_s_o, 0);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ov_off"}, out_valid, 0);
    rd_req = 1'b0;
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_sel_i = 0; cfg_sel_o = 0; cfg_base_w = 0;
    cfg_base_r = 0; cfg_stride = 0; cfg_len = 0; start = 0; in_valid = 0;
    rd_req = 0; v_s_i = 0; h_s_i = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_v", v_s_o, 0);
    chk("rst_h", h_s_o, 0);
    rst = 1'b0;
    tick();

    // 1: vertical write then vertical read
    exp_v[0] = 32'hA0; exp_v[1] = 32'hA1; exp_v[2] = 32'hA2; exp_v[3] = 32'hA3;
    wr_stream("t1w", 2'b10, 8'd4, 8'd1, 4);
    rd_stream("t1r", 2'b10, 8'd4, 8'd1, 4);

    // 2: horizontal, stride 3 wrapping from 0xFE to 0x01, 0x04
    exp_v[0] = 32'd1; exp_v[1] = 32'd2; exp_v[2] = 32'd3;
    wr_stream("t2w", 2'b11, 8'hFE, 8'd3, 3);
    rd_stream("t2r", 2'b11, 8'hFE, 8'd3, 3);
    exp_v[0] = 32'd2; exp_v[1] = 32'd3;
    rd_stream("t2b", 2'b10, 8'h01, 8'd3, 2);

    // 3: same-cycle write/read at address 10 returns the new datum
    do_cfg(2'b10, 2'b10, 8'd10, 8'd10, 8'd1, 8'd1);
    do_start();
    in_valid = 1'b1; rd_req = 1'b1; v_s_i = 32'h55;
    tick();
    in_valid = 1'b0; rd_req = 1'b0;
    chk("t3_ov", out_valid, 1);
    chk("t3_byp", v_s_o, 32'h55);
    tick();
    chk("t3_done", done, 1);
    tick();

    // 4: gapped in_valid 1,0,1,0,1 with a stray mid-run start
    do_cfg(2'b10, 2'b00, 8'h20, 8'h00, 8'd1, 8'd3);
    do_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      v_s_i = 32'hD0 + i;
      start = (i == 1);
      chk($sformatf("t4_nodone%0d", i), done, 0);
      chk($sformatf("t4_busy%0d", i), busy, 1);
      tick();
    end
    start = 1'b0; in_valid = 1'b1; v_s_i = 32'hEE;
    chk("t4_run", done, 0);
    tick();
    in_valid = 1'b0;
    chk("t4_done", done, 1);
    tick();
    chk("t4_idle", busy, 0);

    // 5: len 0 goes straight to DONE, no read, no write
    do_cfg(2'b10, 2'b10, 8'h20, 8'h20, 8'd1, 8'd0);
    do_start();
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 1);
    in_valid = 1'b1; rd_req = 1'b1; v_s_i = 32'h99;
    tick();
    in_valid = 1'b0; rd_req = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_ov", out_valid, 0);
    exp_v[0] = 32'hD0; exp_v[1] = 32'hD2; exp_v[2] = 32'hD4;
    rd_stream("t45r", 2'b10, 8'h20, 8'd1, 3);

    // 6: reset after 2 of 4 writes; the reset-cycle write must not land
    do_cfg(2'b10, 2'b00, 8'h20, 8'h00, 8'd1, 8'd4);
    do_start();
    in_valid = 1'b1;
    v_s_i = 32'hB0; tick();
    v_s_i = 32'hB1; tick();
    v_s_i = 32'hB2; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ov", out_valid, 0);
    chk("t6_v", v_s_o, 0);
    chk("t6_h", h_s_o, 0);
    exp_v[0] = 32'hB0; exp_v[1] = 32'hB1; exp_v[2] = 32'hD4;
    rd_stream("t6r", 2'b11, 8'h20, 8'd1, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
